lcd_sequencer: RTL and testbench
================================

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameter INIT_CMDS, default 4: number of init commands issued after Init (1..16).
REQ-002 Parameter COLS, default 16: characters per display line (2..40).
REQ-003 Parameter ROWS, default 2: display lines (1..4).
REQ-004 Parameter TO_CYCLES, default 1023: max Clk cycles waiting for Done before Error (>=2).
REQ-005 Clk  in  1  single clock; all state updates on the rising edge.
REQ-006 Reset_n  in  1  asynchronous, active-low reset.
REQ-007 Init  in  1  start (or restart) the init sequence; sampled in IDLE or ERROR.
REQ-008 InitCmd  in  8  init command byte for index InitIdx, from an external table.
REQ-009 Lista  in  1  character valid.
REQ-010 Char  in  8  character code, valid with Lista.
REQ-011 Enter  in  1  newline request.
REQ-012 Delete  in  1  backspace request.
REQ-013 Done  in  1  LCD writer finished the current transaction.
REQ-014 InitIdx  out  clog2(INIT_CMDS) (min 1)  index of the init command in progress.
REQ-015 Ejecutar  out  1  one-cycle strobe: DataOut/RS valid, writer starts.
REQ-016 RS  out  1  0 = command, 1 = data.
REQ-017 DataOut  out  8  byte for the writer.
REQ-018 Tomado  out  1  one-cycle pulse: Lista/Enter/Delete request accepted.
REQ-019 Comenzar  out  1  high in IDLE.
REQ-020 Mostrar  out  1  high in READY.
REQ-021 Col  out  clog2(COLS)  cursor column; Row  out  clog2(ROWS) (min 1)  cursor line.
REQ-022 Error  out  1  sticky: Done timeout occurred.

Function
REQ-023 States SHALL be IDLE, INIT_EXEC, INIT_WAIT, READY, EXEC, WAIT, ERROR; EXEC/WAIT serve a micro-sequence of 1..3 transactions.
REQ-024 IDLE: Init -> INIT_EXEC, InitIdx=0, Col=0, Row=0.
REQ-025 INIT_EXEC: Ejecutar=1 for one cycle, RS=0, DataOut=InitCmd; next INIT_WAIT.
REQ-026 INIT_WAIT: Done -> InitIdx+1 and INIT_EXEC, or READY after index INIT_CMDS-1.
REQ-027 Every transaction: DataOut/RS held stable from the Ejecutar cycle until the cycle Done is sampled; Done in any other state is ignored.
REQ-028 Timeout: counter cleared at each Ejecutar; reaching TO_CYCLES in a WAIT state without Done -> ERROR, Error=1.
REQ-029 ERROR: Init -> INIT_EXEC with InitIdx=0, Col=Row=0, Error cleared; otherwise remain.
REQ-030 READY request priority: Delete > Enter > Lista; exactly one accepted per READY cycle, Tomado=1 that cycle, others ignored (not queued).
REQ-031 Character: transaction RS=1, DataOut=Char (latched at acceptance); after Done Col+1; if Col was COLS-1, Col=0, Row=(Row+1) mod ROWS and an address command follows.
REQ-032 Address command: RS=0, DataOut=0x80 | (base[Row]+Col), base = 0x00, 0x40, 0x14, 0x54 for Row 0..3.
REQ-033 Enter: Col=0, Row=(Row+1) mod ROWS, then one address command.
REQ-034 Delete at Col=0, Row=0: no transaction, Tomado still pulses, stay READY.
REQ-035 Delete otherwise: step back (Col-1, or Col=COLS-1 on Row-1), then address, data 0x20, address (3 transactions).
REQ-036 After the last transaction of a sequence completes -> READY on the next cycle.
REQ-037 Init while busy (not IDLE/ERROR) SHALL be ignored.

Reset
REQ-038 Reset_n low SHALL immediately force IDLE, Ejecutar=0, RS=0, DataOut=0x00, Tomado=0, InitIdx=0, Col=0, Row=0, Error=0, timeout counter=0, Comenzar=1, Mostrar=0, independent of Clk, including mid-transaction.

Verification
REQ-039 INIT_CMDS=4, Init pulse, Done 3 cycles after each Ejecutar -> 4 strobes, DataOut = InitCmd for InitIdx 0..3, then Mostrar=1.
REQ-040 READY, COLS=16, 16 chars 'A' -> 16 data strobes, then address 0xC0, Col=0, Row=1.
REQ-041 Row=1 Col=0, Delete -> commands 0x8F, 0x20 (RS=1), 0x8F; Col=15, Row=0.
REQ-042 Lista+Enter+Delete same cycle at Col=Row=0 -> single Tomado, no Ejecutar, Col/Row unchanged.
REQ-043 Done withheld TO_CYCLES cycles -> Error=1, ERROR; Init -> Error=0, InitIdx=0 re-strobe.
REQ-044 Reset_n low mid-WAIT between clock edges -> outputs at reset values immediately; Done afterward ignored.

Source files
------------

// File: rtl/lcd_sequencer_if.sv
// Request/transaction bundle between the LCD sequencer and its environment
// (keyboard-side requests, init command table and the LCD byte writer).
interface lcd_sequencer_if #(
  parameter int INIT_CMDS = 4,
  parameter int COLS      = 16,
  parameter int ROWS      = 2
);
  localparam int IW = (INIT_CMDS > 1) ? $clog2(INIT_CMDS) : 1;
  localparam int CW = $clog2(COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic          Init;
  logic [7:0]    InitCmd;
  logic          Lista;
  logic [7:0]    Char;
  logic          Enter;
  logic          Delete;
  logic          Done;
  logic [IW-1:0] InitIdx;
  logic          Ejecutar;
  logic          RS;
  logic [7:0]    DataOut;
  logic          Tomado;
  logic          Comenzar;
  logic          Mostrar;
  logic [CW-1:0] Col;
  logic [RW-1:0] Row;
  logic          Error;

  modport master (
    input  Init, InitCmd, Lista, Char, Enter, Delete, Done,
    output InitIdx, Ejecutar, RS, DataOut, Tomado, Comenzar, Mostrar, Col, Row, Error
  );

  modport slave (
    output Init, InitCmd, Lista, Char, Enter, Delete, Done,
    input  InitIdx, Ejecutar, RS, DataOut, Tomado, Comenzar, Mostrar, Col, Row, Error
  );
endinterface

// File: rtl/lcd_sequencer.sv
// LCD sequencer: runs the init command table, then turns character/newline/
// backspace requests into 1..3 byte transactions for an LCD writer.
module lcd_sequencer #(
  parameter int INIT_CMDS = 4,
  parameter int COLS      = 16,
  parameter int ROWS      = 2,
  parameter int TO_CYCLES = 1023
) (
  input  logic            Clk,
  input  logic            Reset_n,
  lcd_sequencer_if.master bus
);
  localparam int IW = (INIT_CMDS > 1) ? $clog2(INIT_CMDS) : 1;
  localparam int CW = $clog2(COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TW = $clog2(TO_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, INIT_EXEC, INIT_WAIT, READY, EXEC, WAIT, ERROR
  } state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } txn_t;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] col_q, col_d, ncol_q, ncol_d;
  logic [RW-1:0] row_q, row_d, nrow_q, nrow_d;
  logic          err_q, err_d;
  logic [TW-1:0] to_q, to_d;
  txn_t          cur_q, cur_d, s1_q, s1_d, s2_q, s2_d;
  logic [1:0]    rem_q, rem_d;

  logic          to_hit;
  logic [RW-1:0] row_inc;

  function automatic logic [7:0] addr_cmd(input logic [RW-1:0] r, input logic [CW-1:0] c);
    logic [7:0] base;
    case (int'(r))
      1:       base = 8'h40;
      2:       base = 8'h14;
      3:       base = 8'h54;
      default: base = 8'h00;
    endcase
    return 8'h80 | (base + 8'(c));
  endfunction

  assign to_hit  = (to_q == TW'(TO_CYCLES - 1));
  assign row_inc = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ncol_q  <= '0;
      nrow_q  <= '0;
      err_q   <= 1'b0;
      to_q    <= '0;
      cur_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ncol_q  <= ncol_d;
      nrow_q  <= nrow_d;
      err_q   <= err_d;
      to_q    <= to_d;
      cur_q   <= cur_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    logic [CW-1:0] nc;
    logic [RW-1:0] nr;
    logic [7:0]    a;
    state_d = state_q;
    idx_d   = idx_q;
    col_d   = col_q;
    row_d   = row_q;
    ncol_d  = ncol_q;
    nrow_d  = nrow_q;
    err_d   = err_q;
    to_d    = to_q;
    cur_d   = cur_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    rem_d   = rem_q;
    nc      = col_q;
    nr      = row_q;
    a       = '0;
    case (state_q)
      IDLE, ERROR: begin
        if (bus.Init) begin
          state_d = INIT_EXEC;
          idx_d   = '0;
          col_d   = '0;
          row_d   = '0;
          err_d   = 1'b0;
        end
      end
      INIT_EXEC: begin
        cur_d   = '{rs: 1'b0, data: bus.InitCmd};
        to_d    = '0;
        state_d = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (bus.Done) begin
          if (idx_q == IW'(INIT_CMDS - 1)) begin
            state_d = READY;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = INIT_EXEC;
          end
        end else if (to_hit) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      READY: begin
        // The cursor move is staged in ncol/nrow and committed once the
        // whole micro-sequence has been acknowledged.
        if (bus.Delete) begin
          if (col_q != '0 || row_q != '0) begin
            if (col_q != '0) begin
              nc = col_q - 1'b1;
            end else begin
              nc = CW'(COLS - 1);
              nr = row_q - 1'b1;
            end
            a       = addr_cmd(nr, nc);
            cur_d   = '{rs: 1'b0, data: a};
            s1_d    = '{rs: 1'b1, data: 8'h20};
            s2_d    = '{rs: 1'b0, data: a};
            rem_d   = 2'd2;
            ncol_d  = nc;
            nrow_d  = nr;
            state_d = EXEC;
          end
        end else if (bus.Enter) begin
          cur_d   = '{rs: 1'b0, data: addr_cmd(row_inc, '0)};
          rem_d   = 2'd0;
          ncol_d  = '0;
          nrow_d  = row_inc;
          state_d = EXEC;
        end else if (bus.Lista) begin
          cur_d = '{rs: 1'b1, data: bus.Char};
          if (col_q == CW'(COLS - 1)) begin
            s1_d   = '{rs: 1'b0, data: addr_cmd(row_inc, '0)};
            rem_d  = 2'd1;
            ncol_d = '0;
            nrow_d = row_inc;
          end else begin
            rem_d  = 2'd0;
            ncol_d = col_q + 1'b1;
            nrow_d = row_q;
          end
          state_d = EXEC;
        end
      end
      EXEC: begin
        to_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.Done) begin
          if (rem_q == 2'd0) begin
            col_d   = ncol_q;
            row_d   = nrow_q;
            state_d = READY;
          end else begin
            cur_d   = s1_q;
            s1_d    = s2_q;
            rem_d   = rem_q - 1'b1;
            state_d = EXEC;
          end
        end else if (to_hit) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.Ejecutar = (state_q == INIT_EXEC) || (state_q == EXEC);
    bus.RS       = (state_q == INIT_EXEC) ? 1'b0 : cur_q.rs;
    bus.DataOut  = (state_q == INIT_EXEC) ? bus.InitCmd : cur_q.data;
    bus.Tomado   = (state_q == READY) && (bus.Lista || bus.Enter || bus.Delete);
    bus.Comenzar = (state_q == IDLE);
    bus.Mostrar  = (state_q == READY);
    bus.InitIdx  = idx_q;
    bus.Col      = col_q;
    bus.Row      = row_q;
    bus.Error    = err_q;
  end
endmodule

// File: tb/tb_lcd_sequencer.sv
// Randomized bench for lcd_sequencer: a cursor/transaction model predicts the
// byte stream and cursor for each request while the bench acts as LCD writer.
module tb_lcd_sequencer;
  localparam int NI = 4;
  localparam int NC = 16;
  localparam int NR = 2;
  localparam int TO = 40;
  localparam int IW = 2;
  localparam int CW = 4;
  localparam int RW = 1;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  lcd_sequencer_if #(.INIT_CMDS(NI), .COLS(NC), .ROWS(NR)) bus();
  lcd_sequencer #(.INIT_CMDS(NI), .COLS(NC), .ROWS(NR), .TO_CYCLES(TO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  logic [7:0] init_tab [NI];
  assign bus.InitCmd = init_tab[bus.InitIdx];

  int n_cmp = 0;
  int n_fail = 0;
  int m_col = 0;
  int m_row = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  function automatic logic [8:0] m_addr(input int r, input int c);
    int bases[4] = '{'h00, 'h40, 'h14, 'h54};
    return {1'b0, 8'h80 | 8'(bases[r] + c)};
  endfunction

  // Cursor model: priority Delete > Enter > Lista, each producing its bytes.
  task automatic model_req(input bit l, input bit e, input bit d, input logic [7:0] ch);
    if (d) begin
      if (m_col != 0 || m_row != 0) begin
        if (m_col > 0) m_col--;
        else begin m_col = NC - 1; m_row--; end
        exp_q.push_back(m_addr(m_row, m_col));
        exp_q.push_back(9'h120);
        exp_q.push_back(m_addr(m_row, m_col));
      end
    end else if (e) begin
      m_col = 0;
      m_row = (m_row + 1) % NR;
      exp_q.push_back(m_addr(m_row, 0));
    end else if (l) begin
      exp_q.push_back({1'b1, ch});
      m_col++;
      if (m_col == NC) begin
        m_col = 0;
        m_row = (m_row + 1) % NR;
        exp_q.push_back(m_addr(m_row, 0));
      end
    end
  endtask

  // Acts as the LCD writer until the DUT is back in READY; records every strobe.
  task automatic serve(input int lo, input int hi, input int budget,
                       output bit tmo, output int unst);
    int cd;
    bit pend;
    logic [8:0] cap;
    pend = 0; cd = 0; cap = '0; unst = 0; tmo = 1;
    for (int n = 0; n < budget; n++) begin
      @(negedge Clk);
      if (bus.Done) bus.Done = 1'b0;
      if (pend) begin
        cd--;
        if (cd == 0) begin
          if ({bus.RS, bus.DataOut} !== cap) unst++;
          bus.Done = 1'b1;
          pend = 0;
        end
      end else if (bus.Ejecutar) begin
        cap = {bus.RS, bus.DataOut};
        obs_q.push_back(cap);
        pend = 1;
        cd = $urandom_range(hi, lo);
      end
      if (bus.Mostrar && !pend && !bus.Done) begin
        tmo = 0;
        return;
      end
    end
  endtask

  task automatic do_req(input bit l, input bit e, input bit d, input logic [7:0] ch,
                        output logic tom, output bit tmo, output int unst);
    obs_q.delete();
    exp_q.delete();
    bus.Lista = l; bus.Enter = e; bus.Delete = d; bus.Char = ch;
    #1 tom = bus.Tomado;
    @(posedge Clk);
    #1 bus.Lista = 1'b0; bus.Enter = 1'b0; bus.Delete = 1'b0;
    model_req(l, e, d, ch);
    serve(1, 6, 200, tmo, unst);
  endtask

  task automatic test_reset;
    #3;
    n_cmp++; if (bus.Comenzar !== 1'b1) begin n_fail++; $display("FAIL reset_comenzar got %b want 1", bus.Comenzar); end
    n_cmp++; if (bus.Mostrar !== 1'b0) begin n_fail++; $display("FAIL reset_mostrar got %b want 0", bus.Mostrar); end
    n_cmp++; if (bus.Ejecutar !== 1'b0 || bus.Tomado !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got %b%b want 00", bus.Ejecutar, bus.Tomado); end
    n_cmp++; if ({bus.RS, bus.DataOut} !== 9'h000) begin n_fail++; $display("FAIL reset_data got %h want 000", {bus.RS, bus.DataOut}); end
    n_cmp++; if (bus.Col !== '0 || bus.Row !== '0 || bus.InitIdx !== '0) begin n_fail++; $display("FAIL reset_cursor got %0d/%0d/%0d want 0/0/0", bus.Col, bus.Row, bus.InitIdx); end
    n_cmp++; if (bus.Error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", bus.Error); end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    n_cmp++; if (bus.Comenzar !== 1'b1) begin n_fail++; $display("FAIL idle_hold got %b want 1", bus.Comenzar); end
  endtask

  task automatic test_init;
    bit tmo;
    int unst;
    for (int i = 0; i < NI; i++) init_tab[i] = 8'($urandom);
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < NI; i++) exp_q.push_back({1'b0, init_tab[i]});
    bus.Init = 1'b1;
    @(posedge Clk);
    #1 bus.Init = 1'b0;
    n_cmp++; if (bus.InitIdx !== '0 || bus.Comenzar !== 1'b0) begin n_fail++; $display("FAIL init_start got idx %0d comenzar %b want 0/0", bus.InitIdx, bus.Comenzar); end
    serve(3, 3, 200, tmo, unst);
    n_cmp++; if (tmo || unst != 0) begin n_fail++; $display("FAIL init_serve got tmo %0d unstable %0d want 0/0", tmo, unst); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL init_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL init_cmd%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (bus.Mostrar !== 1'b1) begin n_fail++; $display("FAIL init_ready got %b want 1", bus.Mostrar); end
    m_col = 0; m_row = 0;
  endtask

  task automatic test_wrap;
    logic tom;
    bit tmo;
    int unst;
    for (int k = 0; k < NC; k++) begin
      do_req(1, 0, 0, 8'h41, tom, tmo, unst);
      n_cmp++; if (tom !== 1'b1 || tmo || unst != 0) begin n_fail++; $display("FAIL wrap_req%0d got tom %b tmo %0d unst %0d want 1/0/0", k, tom, tmo, unst); end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_count%0d got %0d want %0d", k, obs_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
        n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_txn%0d got %h want %h", k, obs_q[i], exp_q[i]); end
      end
    end
    n_cmp++; if (obs_q.size() != 2 || obs_q[obs_q.size()-1] !== 9'h0C0) begin n_fail++; $display("FAIL wrap_addr got size %0d want C0 last", obs_q.size()); end
    n_cmp++; if (bus.Col !== 4'd0 || bus.Row !== 1'b1) begin n_fail++; $display("FAIL wrap_cursor got %0d/%0d want 0/1", bus.Col, bus.Row); end
  endtask

  task automatic test_delete_wrap;
    logic tom;
    bit tmo;
    int unst;
    do_req(0, 0, 1, 8'h00, tom, tmo, unst);
    n_cmp++; if (tom !== 1'b1 || tmo || unst != 0) begin n_fail++; $display("FAIL del_req got tom %b tmo %0d unst %0d want 1/0/0", tom, tmo, unst); end
    n_cmp++;
    if (obs_q.size() != 3 || obs_q[0] !== 9'h08F || obs_q[1] !== 9'h120 || obs_q[2] !== 9'h08F) begin
      n_fail++; $display("FAIL del_seq got %0d txns first %h want 08F 120 08F", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 9'h000);
    end
    n_cmp++; if (bus.Col !== 4'd15 || bus.Row !== 1'b0) begin n_fail++; $display("FAIL del_cursor got %0d/%0d want 15/0", bus.Col, bus.Row); end
  endtask

  task automatic test_priority;
    logic tom;
    bit tmo;
    int unst;
    do_req(0, 1, 0, 8'h00, tom, tmo, unst);
    do_req(0, 1, 0, 8'h00, tom, tmo, unst);
    n_cmp++; if (bus.Col !== 4'd0 || bus.Row !== 1'b0 || obs_q.size() != 1 || obs_q[0] !== 9'h080) begin n_fail++; $display("FAIL enter_home got %0d/%0d n %0d want 0/0 addr 080", bus.Col, bus.Row, obs_q.size()); end
    do_req(1, 1, 1, 8'h55, tom, tmo, unst);
    n_cmp++; if (tom !== 1'b1) begin n_fail++; $display("FAIL prio_tomado got %b want 1", tom); end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL prio_noexec got %0d txns want 0", obs_q.size()); end
    n_cmp++; if (bus.Col !== 4'd0 || bus.Row !== 1'b0 || bus.Mostrar !== 1'b1) begin n_fail++; $display("FAIL prio_cursor got %0d/%0d/%b want 0/0/1", bus.Col, bus.Row, bus.Mostrar); end
  endtask

  task automatic test_busy_ignore;
    bit tmo;
    int unst;
    logic [7:0] ch;
    ch = 8'($urandom_range(33, 126));
    obs_q.delete(); exp_q.delete();
    bus.Lista = 1'b1; bus.Char = ch;
    @(posedge Clk);
    #1 bus.Lista = 1'b0;
    model_req(1, 0, 0, ch);
    @(negedge Clk);
    n_cmp++; if (bus.Ejecutar !== 1'b1) begin n_fail++; $display("FAIL busy_strobe got %b want 1", bus.Ejecutar); end
    obs_q.push_back({bus.RS, bus.DataOut});
    bus.Lista = 1'b1; bus.Enter = 1'b1; bus.Delete = 1'b1; bus.Init = 1'b1;
    #1;
    n_cmp++; if (bus.Tomado !== 1'b0) begin n_fail++; $display("FAIL busy_tomado got %b want 0", bus.Tomado); end
    @(posedge Clk);
    #1 bus.Lista = 1'b0; bus.Enter = 1'b0; bus.Delete = 1'b0; bus.Init = 1'b0;
    @(negedge Clk) bus.Done = 1'b1;
    @(posedge Clk);
    #1 bus.Done = 1'b0;
    serve(1, 4, 200, tmo, unst);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL busy_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_txn got %h want %h", obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (tmo || bus.InitIdx !== IW'(NI - 1) || bus.Col !== CW'(m_col) || bus.Row !== RW'(m_row)) begin
      n_fail++; $display("FAIL busy_state got tmo %0d idx %0d cur %0d/%0d want 0 %0d %0d/%0d", tmo, bus.InitIdx, bus.Col, bus.Row, NI - 1, m_col, m_row);
    end
  endtask

  task automatic test_random(input int n);
    logic tom;
    bit tmo;
    int unst;
    bit l, e, d;
    logic [7:0] ch;
    for (int k = 0; k < n; k++) begin
      l = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 4) == 0);
      d = ($urandom_range(0, 3) == 0);
      ch = 8'($urandom_range(32, 126));
      do_req(l, e, d, ch, tom, tmo, unst);
      n_cmp++; if (tom !== (l | e | d) || tmo || unst != 0) begin n_fail++; $display("FAIL rand_req%0d got tom %b tmo %0d unst %0d want %b/0/0", k, tom, tmo, unst, l | e | d); end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count%0d got %0d want %0d", k, obs_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
        n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_txn%0d.%0d got %h want %h", k, i, obs_q[i], exp_q[i]); end
      end
      n_cmp++; if (bus.Col !== CW'(m_col) || bus.Row !== RW'(m_row)) begin n_fail++; $display("FAIL rand_cursor%0d got %0d/%0d want %0d/%0d", k, bus.Col, bus.Row, m_col, m_row); end
    end
  endtask

  task automatic test_timeout;
    int k;
    bit tmo;
    int unst;
    bus.Lista = 1'b1; bus.Char = 8'h5A;
    @(posedge Clk);
    #1 bus.Lista = 1'b0;
    @(negedge Clk);
    n_cmp++; if (bus.Ejecutar !== 1'b1) begin n_fail++; $display("FAIL to_strobe got %b want 1", bus.Ejecutar); end
    for (k = 1; k <= TO + 4; k++) begin
      @(negedge Clk);
      if (bus.Error) break;
    end
    n_cmp++; if (k < TO || k > TO + 1) begin n_fail++; $display("FAIL to_latency got %0d cycles want %0d..%0d", k, TO, TO + 1); end
    n_cmp++; if (bus.Mostrar !== 1'b0 || bus.Comenzar !== 1'b0) begin n_fail++; $display("FAIL to_state got %b%b want 00", bus.Mostrar, bus.Comenzar); end
    bus.Done = 1'b1;
    @(negedge Clk) bus.Done = 1'b0;
    @(negedge Clk);
    n_cmp++; if (bus.Error !== 1'b1 || bus.Mostrar !== 1'b0) begin n_fail++; $display("FAIL to_sticky got %b/%b want 1/0", bus.Error, bus.Mostrar); end
    obs_q.delete();
    bus.Init = 1'b1;
    @(posedge Clk);
    #1 bus.Init = 1'b0;
    n_cmp++; if (bus.Error !== 1'b0 || bus.InitIdx !== '0) begin n_fail++; $display("FAIL to_reinit got err %b idx %0d want 0/0", bus.Error, bus.InitIdx); end
    serve(2, 5, 200, tmo, unst);
    n_cmp++; if (tmo || obs_q.size() != NI || obs_q[0] !== {1'b0, init_tab[0]} || bus.Col !== '0 || bus.Row !== '0) begin
      n_fail++; $display("FAIL to_restrobe got tmo %0d n %0d first %h want 0 %0d %h", tmo, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 9'h000, NI, {1'b0, init_tab[0]});
    end
    m_col = 0; m_row = 0;
  endtask

  task automatic test_reset_mid;
    bus.Lista = 1'b1; bus.Char = 8'h42;
    @(posedge Clk);
    #1 bus.Lista = 1'b0;
    @(negedge Clk);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.Comenzar !== 1'b1 || bus.Mostrar !== 1'b0 || bus.Ejecutar !== 1'b0) begin n_fail++; $display("FAIL midrst_state got %b%b%b want 100", bus.Comenzar, bus.Mostrar, bus.Ejecutar); end
    n_cmp++; if ({bus.RS, bus.DataOut} !== 9'h000 || bus.Col !== '0 || bus.Row !== '0 || bus.Error !== 1'b0) begin n_fail++; $display("FAIL midrst_outs got %h %0d/%0d %b want 000 0/0 0", {bus.RS, bus.DataOut}, bus.Col, bus.Row, bus.Error); end
    @(negedge Clk);
    Reset_n = 1'b1;
    bus.Done = 1'b1;
    @(posedge Clk);
    #1 bus.Done = 1'b0;
    @(negedge Clk);
    n_cmp++; if (bus.Comenzar !== 1'b1 || bus.Ejecutar !== 1'b0 || bus.InitIdx !== '0) begin n_fail++; $display("FAIL midrst_done got %b%b idx %0d want 10 0", bus.Comenzar, bus.Ejecutar, bus.InitIdx); end
  endtask

  initial begin
    bus.Init = 1'b0; bus.Lista = 1'b0; bus.Char = 8'h00;
    bus.Enter = 1'b0; bus.Delete = 1'b0; bus.Done = 1'b0;
    for (int i = 0; i < NI; i++) init_tab[i] = 8'h00;
    test_reset;
    test_init;
    test_wrap;
    test_delete_wrap;
    test_priority;
    test_busy_ignore;
    test_random(60);
    test_timeout;
    test_random(30);
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
